// File: rtl/gps_pkg.sv
// Shared GPS L1 C/A constants: code geometry, LFSR init value and the G2 phase-selector tap table.
package gps_pkg;

  localparam int NUM_PRN    = 36;
  localparam int CA_LEN     = 1023;
  localparam int MS_PER_BIT = 20;

  localparam int CHIP_W = 10;
  localparam int MS_W   = 5;

  localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CA_LEN - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_PER_BIT - 1);

  localparam logic [9:0] G_INIT = 10'h3FF;

  // G2 stage indices (1..10) whose XOR yields the PRN-specific delayed G2 sequence.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } ca_tap_t;

  localparam ca_tap_t CA_TAPS [NUM_PRN] = '{
    '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},  '{4'd1, 4'd9},
    '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},  '{4'd3, 4'd10}, '{4'd2, 4'd3},
    '{4'd3, 4'd4},  '{4'd5, 4'd6},  '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},
    '{4'd9, 4'd10}, '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
    '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},  '{4'd5, 4'd7},
    '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10}, '{4'd1, 4'd6},  '{4'd2, 4'd7},
    '{4'd3, 4'd8},  '{4'd4, 4'd9},  '{4'd5, 4'd10}, '{4'd4, 4'd10}, '{4'd1, 4'd7},
    '{4'd2, 4'd8}
  };

  // Register bit k-1 holds LFSR stage k.
  function automatic logic g_stage(input logic [9:0] g, input logic [3:0] k);
    return g[k - 4'd1];
  endfunction

endpackage

// File: rtl/gold_lfsr_pair.sv
// G1/G2 shift-register pair shared by all PRNs; produces the 36 Gold-code chips combinationally.
module gold_lfsr_pair
  import gps_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic               reload,
  output logic [NUM_PRN-1:0] chips
);

  logic [9:0] g1_q, g1_d;
  logic [9:0] g2_q, g2_d;

  // Stage 1 is bit 0; shifting left moves every stage toward stage 10.
  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (reload) begin
      g1_d = G_INIT;
      g2_d = G_INIT;
    end else if (advance) begin
      g1_d = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
      g2_d = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g1_q <= G_INIT;
      g2_q <= G_INIT;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  always_comb begin
    chips = '0;
    for (int i = 0; i < NUM_PRN; i++) begin
      chips[i] = g1_q[9] ^ g_stage(g2_q, CA_TAPS[i].a) ^ g_stage(g2_q, CA_TAPS[i].b);
    end
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator for PRN 1..36 clocked by a 32-bit chip-rate NCO.
// Emits a chip strobe plus 1 ms code-epoch and 20 ms nav-bit-epoch pulses for the channel stage.
module ca_code_gen
  import gps_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               restart,
  input  logic [31:0]        chip_freq,
  output logic [NUM_PRN-1:0] ca_seq,
  output logic               chip_strobe,
  output logic [CHIP_W-1:0]  chip_cnt,
  output logic               code_epoch,
  output logic               bit_epoch,
  output logic [MS_W-1:0]    ms_cnt
);

  logic [31:0]       acc_q, acc_d, acc_sum;
  logic              carry;
  logic [CHIP_W-1:0] chip_cnt_q, chip_cnt_d;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic              chip_strobe_q, chip_strobe_d;
  logic              code_epoch_q, code_epoch_d;
  logic              bit_epoch_q, bit_epoch_d;
  logic              advance, wrap, reload;

  // The carry out of the phase add is the chip advance; it drives the LFSRs in the same cycle.
  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, chip_freq};
  assign advance = enable & carry & ~restart;
  assign wrap    = advance & (chip_cnt_q == CHIP_LAST);
  assign reload  = restart | wrap;

  gold_lfsr_pair u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .reload  (reload),
    .chips   (ca_seq)
  );

  always_comb begin
    acc_d         = acc_q;
    chip_cnt_d    = chip_cnt_q;
    ms_cnt_d      = ms_cnt_q;
    chip_strobe_d = 1'b0;
    code_epoch_d  = 1'b0;
    bit_epoch_d   = 1'b0;
    if (restart) begin
      acc_d         = '0;
      chip_cnt_d    = '0;
      ms_cnt_d      = '0;
      chip_strobe_d = 1'b1;
      code_epoch_d  = 1'b1;
      bit_epoch_d   = 1'b1;
    end else if (enable) begin
      acc_d = acc_sum;
      if (carry) begin
        chip_strobe_d = 1'b1;
        if (chip_cnt_q == CHIP_LAST) begin
          chip_cnt_d   = '0;
          code_epoch_d = 1'b1;
          if (ms_cnt_q == MS_LAST) begin
            ms_cnt_d    = '0;
            bit_epoch_d = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end else begin
          chip_cnt_d = chip_cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: all next-state logic lives in always_comb with a default for every signal, so no
  // latches form; this block only copies _d to _q with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      chip_cnt_q    <= '0;
      ms_cnt_q      <= '0;
      chip_strobe_q <= 1'b0;
      code_epoch_q  <= 1'b0;
      bit_epoch_q   <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      chip_cnt_q    <= chip_cnt_d;
      ms_cnt_q      <= ms_cnt_d;
      chip_strobe_q <= chip_strobe_d;
      code_epoch_q  <= code_epoch_d;
      bit_epoch_q   <= bit_epoch_d;
    end
  end

  assign chip_strobe = chip_strobe_q;
  assign chip_cnt    = chip_cnt_q;
  assign code_epoch  = code_epoch_q;
  assign bit_epoch   = bit_epoch_q;
  assign ms_cnt      = ms_cnt_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen: cycle-accurate scoreboard model plus directed vectors
// for the first chips, period/epoch timing, enable freeze, restart and reset.
module tb_ca_code_gen;

  logic        clk = 1'b0;
  logic        reset, enable, restart;
  logic [31:0] chip_freq;
  logic [35:0] ca_seq;
  logic        chip_strobe, code_epoch, bit_epoch;
  logic [9:0]  chip_cnt;
  logic [4:0]  ms_cnt;

  always #5 clk = ~clk;

  ca_code_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .chip_freq   (chip_freq),
    .ca_seq      (ca_seq),
    .chip_strobe (chip_strobe),
    .chip_cnt    (chip_cnt),
    .code_epoch  (code_epoch),
    .bit_epoch   (bit_epoch),
    .ms_cnt      (ms_cnt)
  );

  typedef struct packed {
    logic [35:0] ca;
    logic        strobe;
    logic [9:0]  chip;
    logic        code_ep;
    logic        bit_ep;
    logic [4:0]  ms;
  } out_t;

  typedef struct {
    bit [31:0] freq;
    bit        exp_strobe;
    int        exp_chip;
    bit [2:0]  exp_bits;   // {PRN5, PRN2, PRN1}
  } vec_t;

  localparam logic [35:0] ALL_ONES = 36'hF_FFFF_FFFF;
  localparam bit [31:0]   F_HALF   = 32'h8000_0000;
  localparam bit [31:0]   F_FRAC   = 32'h6000_0000;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  out_t exp_q[$];
  out_t dut_o;

  // Reference model state; stage k of each LFSR is index k.
  bit [31:0] m_acc;
  bit [32:0] m_sum;
  bit [10:1] m_g1, m_g2;
  int        m_chip, m_ms;
  bit        m_strobe, m_ce, m_be;

  int tap_a[36] = '{2,3,4,5,1,2,1,2,3, 2,3,5,6,7,8,9,1,2, 3,4,5,6,1,4,5,6,7, 8,1,2,3,4,5,4,1,2};
  int tap_b[36] = '{6,7,8,9,9,10,8,9,10, 3,4,6,7,8,9,10,4,5, 6,7,8,9,3,6,7,8,9, 10,6,7,8,9,10,10,7,8};

  vec_t      vecs[18];
  logic [9:0] p1_ref, p2_ref, p5_ref;

  int  edge_n, last_ep_edge, epochs, ones, prev_chip;
  bit  found;
  out_t snap;
  logic [35:0] ref_ca[$], run_ca[$];
  int          ref_ix[$], run_ix[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit rs, input bit [31:0] f);
    bit fb1, fb2;
    m_strobe = 1'b0;
    m_ce     = 1'b0;
    m_be     = 1'b0;
    if (rst) begin
      m_acc = '0; m_g1 = '1; m_g2 = '1; m_chip = 0; m_ms = 0;
    end else if (rs) begin
      m_acc = '0; m_g1 = '1; m_g2 = '1; m_chip = 0; m_ms = 0;
      m_strobe = 1'b1; m_ce = 1'b1; m_be = 1'b1;
    end else if (en) begin
      m_sum = {1'b0, m_acc} + {1'b0, f};
      m_acc = m_sum[31:0];
      if (m_sum[32]) begin
        m_strobe = 1'b1;
        if (m_chip == 1022) begin
          m_chip = 0; m_g1 = '1; m_g2 = '1; m_ce = 1'b1;
          if (m_ms == 19) begin
            m_ms = 0; m_be = 1'b1;
          end else begin
            m_ms++;
          end
        end else begin
          m_chip++;
          fb1 = m_g1[3] ^ m_g1[10];
          fb2 = m_g2[2] ^ m_g2[3] ^ m_g2[6] ^ m_g2[8] ^ m_g2[9] ^ m_g2[10];
          m_g1 = {m_g1[9:1], fb1};
          m_g2 = {m_g2[9:1], fb2};
        end
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    for (int i = 0; i < 36; i++) o.ca[i] = m_g1[10] ^ m_g2[tap_a[i]] ^ m_g2[tap_b[i]];
    o.strobe  = m_strobe;
    o.chip    = 10'(m_chip);
    o.code_ep = m_ce;
    o.bit_ep  = m_be;
    o.ms      = 5'(m_ms);
    return o;
  endfunction

  // Drive one cycle, queue the model's prediction, sample #1 after the edge and compare.
  task automatic step(input bit rst, input bit en, input bit rs, input bit [31:0] f);
    out_t e;
    reset = rst; enable = en; restart = rs; chip_freq = f;
    model_step(rst, en, rs, f);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    dut_o = {ca_seq, chip_strobe, chip_cnt, code_epoch, bit_epoch, ms_cnt};
    e = exp_q.pop_front();
    check("scoreboard", 64'(dut_o), 64'(e));
  endtask

  task automatic monitor();
    edge_n++;
    if (dut_o.code_ep) begin
      epochs++;
      check("epoch_spacing", 64'(edge_n - last_ep_edge), 64'd2046);
      last_ep_edge = edge_n;
      check("epoch_prev_chip", 64'(prev_chip), 64'd1022);
      check("epoch_chip0", 64'(dut_o.chip), 64'd0);
      check("epoch_ca_ones", 64'(dut_o.ca), 64'(ALL_ONES));
      check("epoch_ms", 64'(dut_o.ms), 64'(epochs % 20));
      check("bit_epoch_at_epoch", 64'(dut_o.bit_ep), 64'(epochs == 20));
      if (epochs == 1) check("prn1_ones", 64'(ones), 64'd512);
    end else begin
      if (dut_o.bit_ep) check("bit_epoch_without_code_epoch", 64'(dut_o.bit_ep), 64'd0);
      if (epochs == 0 && dut_o.strobe) ones += int'(dut_o.ca[0]);
    end
    prev_chip = int'(dut_o.chip);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p1_ref = 10'b1100100000;
    p2_ref = 10'b1110010000;
    p5_ref = 10'b1001011011;
    for (int k = 0; k < 18; k++) begin
      int n;
      n = (k + 1) / 2;
      vecs[k].freq       = F_HALF;
      vecs[k].exp_strobe = (k % 2 == 1);
      vecs[k].exp_chip   = n;
      vecs[k].exp_bits   = {p5_ref[9-n], p2_ref[9-n], p1_ref[9-n]};
    end

    reset = 1'b1; enable = 1'b0; restart = 1'b0; chip_freq = '0;

    // Reset state, then the first chips from the table.
    step(1, 1, 0, F_HALF);
    check("reset_vals", 64'({ca_seq, chip_cnt, ms_cnt, chip_strobe, code_epoch, bit_epoch}),
          64'({ALL_ONES, 10'd0, 5'd0, 3'b000}));
    edge_n = 0; last_ep_edge = 0; epochs = 0; prev_chip = 0;
    ones = int'(dut_o.ca[0]);
    for (int k = 0; k < 18; k++) begin
      step(0, 1, 0, vecs[k].freq);
      check($sformatf("vec%0d_strobe", k), 64'(dut_o.strobe), 64'(vecs[k].exp_strobe));
      check($sformatf("vec%0d_chip", k), 64'(dut_o.chip), 64'(vecs[k].exp_chip));
      check($sformatf("vec%0d_prn1_2_5", k), 64'({dut_o.ca[4], dut_o.ca[1], dut_o.ca[0]}),
            64'(vecs[k].exp_bits));
      monitor();
    end

    // Twenty full code periods at half chip rate.
    for (int c = 0; c < 20 * 2046 + 100 && epochs < 20; c++) begin
      step(0, 1, 0, F_HALF);
      monitor();
    end
    check("epochs_seen", 64'(epochs), 64'd20);

    // Reference run for the enable-freeze comparison.
    step(1, 0, 0, F_FRAC);
    for (int c = 0; c < 300; c++) step(0, 1, 0, F_FRAC);
    for (int c = 0; c < 60; c++) begin
      step(0, 1, 0, F_FRAC);
      if (dut_o.strobe) begin
        ref_ca.push_back(dut_o.ca);
        ref_ix.push_back(c);
      end
    end

    // Same run with enable low for 7 cycles mid-period.
    step(1, 0, 0, F_FRAC);
    for (int c = 0; c < 300; c++) step(0, 1, 0, F_FRAC);
    snap = dut_o;
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 0, F_FRAC);
      check("freeze_hold", 64'({dut_o.ca, dut_o.chip, dut_o.ms}), 64'({snap.ca, snap.chip, snap.ms}));
      check("freeze_no_pulse", 64'({dut_o.strobe, dut_o.code_ep, dut_o.bit_ep}), 64'd0);
    end
    for (int c = 0; c < 60; c++) begin
      step(0, 1, 0, F_FRAC);
      if (dut_o.strobe) begin
        run_ca.push_back(dut_o.ca);
        run_ix.push_back(c);
      end
    end
    check("resume_len", 64'(run_ca.size()), 64'(ref_ca.size()));
    for (int i = 0; i < ref_ca.size() && i < run_ca.size(); i++) begin
      check($sformatf("resume_ca%0d", i), 64'(run_ca[i]), 64'(ref_ca[i]));
      check($sformatf("resume_ix%0d", i), 64'(run_ix[i]), 64'(ref_ix[i]));
    end

    // Restart on a carry cycle at chip 500 of ms 1.
    step(1, 0, 0, F_HALF);
    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      step(0, 1, 0, F_HALF);
      if (dut_o.ms == 5'd1 && dut_o.chip == 10'd500 && dut_o.strobe) found = 1'b1;
    end
    check("restart_target_reached", 64'(found), 64'd1);
    step(0, 1, 0, F_HALF);
    check("pre_restart_no_carry", 64'({dut_o.strobe, dut_o.chip}), 64'({1'b0, 10'd500}));
    step(0, 1, 1, F_HALF);
    check("restart_vals", 64'({dut_o.ca, dut_o.chip, dut_o.ms}), 64'({ALL_ONES, 10'd0, 5'd0}));
    check("restart_pulses", 64'({dut_o.strobe, dut_o.code_ep, dut_o.bit_ep}), 64'd7);
    for (int c = 0; c < 6; c++) step(0, 1, 0, F_HALF);
    check("after_restart_chip", 64'(dut_o.chip), 64'd3);

    // Restart while disabled still realigns and pulses.
    step(0, 0, 1, F_HALF);
    check("restart_disabled", 64'({dut_o.chip, dut_o.strobe, dut_o.code_ep, dut_o.bit_ep}),
          64'({10'd0, 3'b111}));

    // Reset mid-period with enable high, then reset together with restart.
    for (int c = 0; c < 75; c++) step(0, 1, 0, F_FRAC);
    step(1, 1, 0, F_FRAC);
    check("reset_mid_vals", 64'({dut_o.ca, dut_o.chip, dut_o.ms, dut_o.strobe, dut_o.code_ep, dut_o.bit_ep}),
          64'({ALL_ONES, 10'd0, 5'd0, 3'b000}));
    step(1, 1, 1, F_FRAC);
    check("reset_over_restart", 64'({dut_o.strobe, dut_o.code_ep, dut_o.bit_ep}), 64'd0);
    step(0, 1, 0, F_FRAC);
    step(0, 1, 0, F_FRAC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ca_code_gen.md
Name: ca_code_gen

Overview:
- Upstream feeder of the per-SV channel stage. Produces the 36-bit `ca_seq` bus: one GPS L1 C/A Gold-code chip per PRN 1..36, bit i = PRN i+1.
- A 32-bit chip-rate NCO advances shared G1/G2 LFSRs.
- Code-epoch (1 ms) and nav-bit-epoch (20 ms) pulses are emitted for downstream data modulation and timing.
- One instance serves all satellite channels; each channel selects its PRN from the bus.

Parameters:
- NUM_PRN, 36, number of PRN outputs (must equal width of `ca_seq`)
- CA_LEN, 1023, chips per code period
- MS_PER_BIT, 20, code periods per nav data bit

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  advance NCO/code when high; hold all state when low
- restart  in  1  single-cycle pulse; returns code state to chip 0 of ms 0 without full reset
- chip_freq  in  32  NCO increment = f_chip/f_clk * 2^32 (nominal 1.023 MHz, carries Doppler on code)
- ca_seq  out  36  current chip for each PRN, 1 = multiply by -1
- chip_strobe  out  1  one-cycle pulse, coincident with each `ca_seq` update
- chip_cnt  out  10  current chip index 0..1022
- code_epoch  out  1  one-cycle pulse with the update that enters chip 0
- bit_epoch  out  1  one-cycle pulse with the `code_epoch` that enters ms 0
- ms_cnt  out  5  code period index 0..19

Behaviour:
- Reset values (reset has priority over everything):
  - phase accumulator = 0; G1 = G2 = 10'h3FF
  - chip_cnt = 0; ms_cnt = 0
  - ca_seq = 36'hF_FFFF_FFFF (all-ones LFSR state gives chip 1 on every PRN)
  - chip_strobe = code_epoch = bit_epoch = 0
- NCO: when enable, acc <= acc + chip_freq (32-bit wrap). The carry-out is the chip advance. No advance when enable = 0; all outputs hold and pulses are 0.
- Advance at cycle N: all registered outputs update at N+1, i.e. latency 1 clk from the carry cycle.
- LFSRs (stages numbered 1..10, shift toward 10):
  - G1 feedback = s3 ^ s10
  - G2 feedback = s2 ^ s3 ^ s6 ^ s8 ^ s9 ^ s10
- Output: ca_seq[i] = G1.s10 ^ G2.sA_i ^ G2.sB_i, taken from the post-advance state.
- Tap pairs (A,B) for PRN 1..36:
  - PRN 1-9: (2,6) (3,7) (4,8) (5,9) (1,9) (2,10) (1,8) (2,9) (3,10)
  - PRN 10-18: (2,3) (3,4) (5,6) (6,7) (7,8) (8,9) (9,10) (1,4) (2,5)
  - PRN 19-27: (3,6) (4,7) (5,8) (6,9) (1,3) (4,6) (5,7) (6,8) (7,9)
  - PRN 28-36: (8,10) (1,6) (2,7) (3,8) (4,9) (5,10) (4,10) (1,7) (2,8)
- Wrap: an advance with chip_cnt == 1022 does all of the following:
  - chip_cnt <= 0
  - G1 and G2 forced to 3FF (this enforces period alignment even if state were corrupted)
  - code_epoch = 1
  - ms_cnt increments; at 19 it wraps to 0 and bit_epoch = 1
- restart: same-cycle effect identical to reset except chip_strobe = 1, code_epoch = 1 and bit_epoch = 1 on the next cycle. This lets downstream realign.
  - restart overrides a coincident carry.
  - restart applies regardless of enable.
- Timing budget: the carry from a 32-bit add feeds the LFSR enable. Pipelining the add is not permitted because latency is fixed at 1.

Decomposition:
- Shared package `gps_pkg`:
  - NUM_PRN, CA_LEN, MS_PER_BIT
  - `ca_tap_t` (struct of two 4-bit stage indices)
  - constant array CA_TAPS[36]
  - G1/G2 init value 10'h3FF
- One sub-module `gold_lfsr_pair`: holds G1/G2, inputs advance/reload, outputs the 36 combinational chips.
- The NCO, counters and pulses stay in the top level.

Test Plan:
- Reset then enable = 1, chip_freq = 32'h8000_0000 -> chip_strobe every 2nd clk. The first 10 chips (including the reset chip) must be:
  - PRN1: 1100100000
  - PRN2: 1110010000
  - PRN5: 1001011011
- Run a full period at chip_freq = 2^31 -> code_epoch exactly once per 2046 clks and chip_cnt 1022->0. After epoch, ca_seq = all ones again. The sum over 1023 chips of PRN1 = 512 ones.
- Run 20 periods -> bit_epoch once, coincident with the 20th code_epoch. ms_cnt sequence 0..19->0.
- Toggle enable low for 7 clks mid-period -> acc, chip_cnt and ca_seq frozen, no pulses. Resumes with the identical chip sequence, delayed 7 clks.
- Assert restart on a carry cycle at chip_cnt = 500 -> next cycle chip_cnt = 0, ms_cnt = 0, ca_seq = 36'hF_FFFF_FFFF, and all three pulses = 1.
- Assert reset while enable = 1 mid-period -> the next cycle matches the reset values and pulses are 0. Reset held with restart = 1 gives no pulses.
